// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared constants and FSM encoding for the fetch stage
package if_prefetch_queue_pkg;
  localparam int FETCH_Q_DEPTH = 4;
  localparam int FETCH_Q_DEPTH_LOG2 = 2;
  localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  typedef enum logic {FETCH_IDLE = 1'b0, FETCH_RUN = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop and flush plus occupancy flags
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst | flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: PC owner and ROM driver that buffers fetched instructions for ID
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_VALUE)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i
);
  fetch_state_t state;
  logic [ADDR_W-1:0] pc, target;
  logic [ADDR_W+INST_W-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, pop, push, redirect;
  assign redirect = flush_i | branch_flag_i;
  assign target = flush_i ? new_pc_i : branch_target_i;
  assign pop = id_valid_o & id_ready_i;
  assign push = (state == FETCH_RUN) & (~full | pop) & ~redirect;
  assign rom_ce_o = (state == FETCH_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = pc;
  assign id_valid_o = count != '0;
  assign id_pc_o = empty ? '0 : head[ADDR_W+INST_W-1:INST_W];
  assign id_inst_o = empty ? INST_W'(ZERO_WORD) : head[INST_W-1:0];
  // When full without a pop, pc holds so the same address is simply re-read.
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH_IDLE;
      pc <= RESET_PC;
    end else begin
      state <= FETCH_RUN;
      pc <= redirect ? {target[ADDR_W-1:2], 2'b00} : push ? pc + ADDR_W'(4) : pc;
    end
  fetch_fifo #(.W(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din({pc, rom_inst_i}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed and random checks against a queue-based fetch model
module tb_if_prefetch_queue;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic clk = 0, rst = 1, id_ready = 0, branch_flag = 0, flush = 0;
  logic [31:0] branch_target = 0, new_pc = 0, rom_addr, rom_inst, id_pc, id_inst;
  logic rom_ce, id_valid;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  ent_t q[$];
  logic [31:0] mpc = 0;
  bit mrun = 0;

  if_prefetch_queue dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .id_ready_i(id_ready),
    .branch_flag_i(branch_flag), .branch_target_i(branch_target), .flush_i(flush), .new_pc_i(new_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign rom_inst = rom(rom_addr);

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ID sees a plain FIFO of {pc, rom(pc)}; redirect empties it and moves pc.
  task automatic model_step();
    bit pop;
    if (rst) begin
      q.delete();
      mpc = 32'h0;
      mrun = 0;
      return;
    end
    pop = q.size() > 0 && id_ready;
    if (flush || branch_flag) begin
      q.delete();
      mpc = (flush ? new_pc : branch_target) & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(q.pop_front());
      if (mrun && q.size() < 4) begin
        q.push_back('{mpc, rom(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    mrun = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("rom_ce", {31'b0, rom_ce}, {31'b0, mrun});
      chk("rom_addr", rom_addr, mpc);
      chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() > 0});
      chk("id_pc", id_pc, q.size() > 0 ? q[0].pc : 32'h0);
      chk("id_inst", id_inst, q.size() > 0 ? q[0].inst : 32'h0);
    end

  task automatic do_reset(input bit ready);
    rst = 1; id_ready = ready; branch_flag = 0; flush = 0;
    repeat (3) cycle();
    rst = 0;
  endtask

  initial begin
    // 1. reset sequence
    rst = 1; id_ready = 1;
    repeat (3) begin
      cycle();
      chk_en = 1;
      chk("rst_ce", {31'b0, rom_ce}, 32'h0);
      chk("rst_addr", rom_addr, 32'h0);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
    end
    rst = 0;
    #1 chk("idle_ce", {31'b0, rom_ce}, 32'h0);
    cycle();
    chk("run_ce", {31'b0, rom_ce}, 32'h1);
    chk("run_addr", rom_addr, 32'h0);
    chk("run_valid", {31'b0, id_valid}, 32'h0);
    cycle();
    chk("first_valid", {31'b0, id_valid}, 32'h1);
    chk("first_pc", id_pc, 32'h0);
    chk("first_inst", id_inst, rom(32'h0));
    // 2. streaming, no bubbles
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("stream_pc", id_pc, 32'(4 * i));
      chk("stream_inst", id_inst, rom(32'(4 * i)));
    end
    // 3. stall until full, then drain back-to-back
    do_reset(0);
    repeat (8) cycle();
    chk("stall_addr", rom_addr, 32'h10);
    chk("stall_head", id_pc, 32'h0);
    id_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      #1 chk("drain_pc", id_pc, 32'(4 * i));
      chk("drain_valid", {31'b0, id_valid}, 32'h1);
      cycle();
    end
    // 4. branch with three entries queued
    do_reset(0);
    repeat (4) cycle();
    chk("br_addr_pre", rom_addr, 32'hC);
    branch_flag = 1; branch_target = 32'h100;
    cycle();
    chk("br_valid", {31'b0, id_valid}, 32'h0);
    chk("br_addr", rom_addr, 32'h100);
    branch_flag = 0;
    cycle();
    chk("br_head", id_pc, 32'h100);
    branch_flag = 1; branch_target = 32'h103;
    cycle();
    chk("br_align", rom_addr, 32'h100);
    branch_flag = 0;
    // 5. flush beats branch, pop discarded
    repeat (3) cycle();
    id_ready = 1; flush = 1; new_pc = 32'h380; branch_flag = 1; branch_target = 32'h200;
    cycle();
    chk("pri_addr", rom_addr, 32'h380);
    chk("pri_valid", {31'b0, id_valid}, 32'h0);
    flush = 0; branch_flag = 0;
    cycle();
    chk("pri_head", id_pc, 32'h380);
    // 6. reset beats a pending branch on a full queue
    id_ready = 0;
    repeat (6) cycle();
    rst = 1; branch_flag = 1; branch_target = 32'h500;
    cycle();
    chk("mid_ce", {31'b0, rom_ce}, 32'h0);
    chk("mid_addr", rom_addr, 32'h0);
    chk("mid_valid", {31'b0, id_valid}, 32'h0);
    chk("mid_pc", id_pc, 32'h0);
    chk("mid_inst", id_inst, 32'h0);
    rst = 0; branch_flag = 0;
    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      id_ready = $urandom_range(0, 2) != 0;
      branch_flag = $urandom_range(0, 15) == 0;
      flush = $urandom_range(0, 31) == 0;
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      new_pc = $urandom;
      cycle();
    end
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
